servo_pwm_stepper: RTL
======================

# servo_pwm_stepper

Converts the keyboard-derived direction levels (`isClockWise`, `isCounterClock`) into a 50 Hz hobby-servo PWM whose pulse width ramps while a key is held and stays put when it is released. It sits directly downstream of the keyboard decode in the arm top level and drives the FPGA pin `servo`. Pulse-width updates land only on frame boundaries, so the servo never sees a truncated or stretched pulse.

## Interface
- `PERIOD_CYCLES`, 2_000_000: clk cycles per PWM frame (20 ms at 100 MHz).
- `MIN_PULSE`, 50_000: minimum high time in cycles (0.5 ms).
- `MAX_PULSE`, 250_000: maximum high time in cycles (2.5 ms).
- `CENTER_PULSE`, 150_000: high time after reset (1.5 ms).
- `STEP`, 1_000: pulse-width change per frame while a direction is held.
- `CNT_W`, 21: counter/width bit width; must satisfy 2^CNT_W > PERIOD_CYCLES.
- `clk`, in, 1: system clock, 100 MHz. One clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `isClockWise`, in, 1: level, high while the "up" key is held.
- `isCounterClock`, in, 1: level, high while the "down" key is held.
- `servo`, out, 1: registered PWM output.
- `position`, out, CNT_W: currently applied pulse width in cycles.
- `at_limit`, out, 1: high when `position` equals MIN_PULSE or MAX_PULSE.

## Operation
- Frame counter `cnt` runs 0 .. PERIOD_CYCLES-1 and wraps to 0.
- Direction decode happens in the cycle where `cnt == PERIOD_CYCLES-1`:
  - CW only: `width = min(width + STEP, MAX_PULSE)`.
  - CCW only: `width = max(width - STEP, MIN_PULSE)`.
  - Both held or neither held: width is unchanged.
- The add is done at CNT_W+1 bits before the clamp. The subtract compares `width - MIN_PULSE` against STEP first, so it never underflows.
- The new width is written on that same edge, so it applies to the frame whose `cnt` starts at 0.
- PWM output: `servo <= (cnt < width)`.
- Result: exactly `width` high cycles per frame, then low for the rest of the frame.
- `position` is the width register itself. `at_limit` is a combinational compare on `position`.
- Direction inputs are not sampled mid-frame. A press shorter than one frame that does not span a frame boundary is ignored.

## Timing
- Reset values:
  - `cnt` = 0
  - width/`position` = CENTER_PULSE
  - `servo` = 0
  - `at_limit` = 0 (if CENTER_PULSE is not itself a limit)
- First cycle after `rst` deasserts: `cnt` = 0, and `servo` goes high on the following edge. There is one cycle of output latency relative to `cnt`.
- Reset asserted mid-frame:
  - On the next edge, `servo` = 0, `cnt` = 0, width = CENTER_PULSE, and any accumulated ramp (including the accel count) is lost.
  - The frame restarts cleanly after release.
- Latency from holding a key to a changed pulse: the key is sampled at the end of the current frame, and the new width appears in the next frame, so at most 1 frame plus 1 cycle.
- Saturation: once at a limit, further presses toward that limit hold the width. `at_limit` stays high until a press in the opposite direction moves the width off the limit.

## Configuration
- `SERVO_ACCEL_EN` defined:
  - A 5-bit hold counter counts consecutive frames with the same single direction.
  - It saturates at 25. At 25 the effective step becomes 4*STEP, still clamped to the limits.
  - A direction change, release, both-held, or reset clears the counter and restores STEP.
- `SERVO_ACCEL_EN` undefined: the step is always STEP and no hold counter exists.

## Structure
- Shared package `servo_pkg`:
  - default frame, pulse, and step constants
  - `CNT_W`
  - direction enum `{DIR_HOLD, DIR_CW, DIR_CCW}` produced by the decode
- One sub-module, `servo_frame_timer`:
  - owns `cnt`
  - emits `frame_end` (high when `cnt == PERIOD_CYCLES-1`)
  - exports `cnt` for the PWM compare
- The top block holds the width register, clamp arithmetic, optional accel counter and the output register.

## Test plan
Bench overrides: PERIOD_CYCLES=1000, MIN_PULSE=50, MAX_PULSE=250, CENTER_PULSE=150, STEP=10.
- Reset then idle for 3 frames: `servo` high for exactly 150 cycles per frame, low for 850; `position` = 150; `at_limit` = 0.
- Hold CW across 3 frame boundaries: successive frames show high times 160, 170, 180.
- Hold CW for 12 frames from 150: width reaches 250 and stays; `at_limit` = 1. Then hold CCW for 1 frame: 240, `at_limit` = 0.
- Hold CCW from 60 for 2 frames: 50, 50 (no underflow). Assert both inputs for 2 frames: width unchanged.
- Reach width 200, then assert `rst` at `cnt` = 500 for 1 cycle: next edge `servo` = 0 and `position` = 150; the next frame has 150 high cycles.
- With `SERVO_ACCEL_EN`: after 25 CW frames from 50, `position` = 300 clamped to 250. From MIN with MAX_PULSE=1000: frame 26 step is 40. Releasing for one frame restores step 10.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and direction decode for the keyboard-driven servo PWM stepper.
package servo_pkg;

    localparam int DEF_PERIOD_CYCLES = 2_000_000;
    localparam int DEF_MIN_PULSE     = 50_000;
    localparam int DEF_MAX_PULSE     = 250_000;
    localparam int DEF_CENTER_PULSE  = 150_000;
    localparam int DEF_STEP          = 1_000;
    localparam int DEF_CNT_W         = 21;

    typedef enum logic [1:0] {DIR_HOLD, DIR_CW, DIR_CCW} dir_e;

    // Both keys together cancel out, same as no key.
    function automatic dir_e decode_dir(input logic cw, input logic ccw);
        dir_e d;
        d = DIR_HOLD;
        if (cw && !ccw) d = DIR_CW;
        else if (ccw && !cw) d = DIR_CCW;
        return d;
    endfunction

endpackage

// File: rtl/servo_pwm_stepper_if.sv
// Direction levels in, PWM pin and position status out.
interface servo_pwm_stepper_if #(
    parameter int CNT_W = servo_pkg::DEF_CNT_W
);
    logic             isClockWise;
    logic             isCounterClock;
    logic             servo;
    logic [CNT_W-1:0] position;
    logic             at_limit;

    modport master (
        output isClockWise, isCounterClock,
        input  servo, position, at_limit
    );

    modport slave (
        input  isClockWise, isCounterClock,
        output servo, position, at_limit
    );
endinterface

// File: rtl/servo_frame_timer.sv
// PWM frame counter: counts 0..PERIOD_CYCLES-1 and flags the last cycle of each frame.
module servo_frame_timer #(
    parameter int PERIOD_CYCLES = servo_pkg::DEF_PERIOD_CYCLES,
    parameter int CNT_W         = servo_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_end
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    assign frame_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || frame_end) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/servo_pwm_stepper.sv
// Ramping hobby-servo PWM; width changes only on frame boundaries.
// Optional build macro SERVO_ACCEL_EN: 4x step after 25 consecutive same-direction frames.
module servo_pwm_stepper #(
    parameter int PERIOD_CYCLES = servo_pkg::DEF_PERIOD_CYCLES,
    parameter int MIN_PULSE     = servo_pkg::DEF_MIN_PULSE,
    parameter int MAX_PULSE     = servo_pkg::DEF_MAX_PULSE,
    parameter int CENTER_PULSE  = servo_pkg::DEF_CENTER_PULSE,
    parameter int STEP          = servo_pkg::DEF_STEP,
    parameter int CNT_W         = servo_pkg::DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    servo_pwm_stepper_if.slave bus
);
    import servo_pkg::*;

    localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(MIN_PULSE);
    localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(MAX_PULSE);
    localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] CEN_C  = CNT_W'(CENTER_PULSE);

    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic [CNT_W-1:0] width, width_nxt;
    logic [CNT_W:0]   step, sum, diff;
    logic             servo_q;
    dir_e             dir;

    servo_frame_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .frame_end(frame_end)
    );

    assign dir = decode_dir(bus.isClockWise, bus.isCounterClock);

`ifdef SERVO_ACCEL_EN
    localparam logic [4:0] HOLD_MAX = 5'd25;
    logic [4:0] hold_cnt;
    dir_e       last_dir;

    // hold_cnt is the number of same-direction frames already applied.
    assign step = (hold_cnt == HOLD_MAX && dir == last_dir && dir != DIR_HOLD)
                  ? (STEP_W << 2) : STEP_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            last_dir <= DIR_HOLD;
        end else if (frame_end) begin
            last_dir <= dir;
            if (dir == DIR_HOLD)          hold_cnt <= '0;
            else if (dir != last_dir)     hold_cnt <= 5'd1;
            else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 5'd1;
        end
    end
`else
    assign step = STEP_W;
`endif

    // One spare bit on the add; subtract checks headroom first so it cannot wrap.
    assign sum  = {1'b0, width} + step;
    assign diff = {1'b0, width} - MIN_W;

    always_comb begin
        width_nxt = width;
        case (dir)
            DIR_CW:  width_nxt = (sum > MAX_W) ? MAX_C : sum[CNT_W-1:0];
            DIR_CCW: width_nxt = (diff >= step) ? (width - step[CNT_W-1:0]) : MIN_C;
            default: width_nxt = width;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width   <= CEN_C;
            servo_q <= 1'b0;
        end else begin
            if (frame_end) width <= width_nxt;
            servo_q <= (cnt < width);
        end
    end

    assign bus.servo    = servo_q;
    assign bus.position = width;
    assign bus.at_limit = (width == MIN_C) || (width == MAX_C);
endmodule
